conv2d_window_gen: RTL

Sliding-window generator that sits directly upstream of `conv2d_pe_array`. It accepts a raster-order, multi-channel pixel stream and keeps K-1 line buffers per channel. For each valid (no-padding, stride-1) output position it presents a stable K×K window per channel, pulses `start` to the PE array, and stalls input until the array reports completion. The window bus feeds `window_per_channel` directly; the array's `out_valid` returns as `pe_done`.

---
 rtl/conv2d_window_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conv2d_window_gen.sv
// Sliding K x K window generator for conv2d_pe_array: per-channel line buffers
// plus a window register, with a start/pe_done handshake that stalls the pixel stream.
module conv2d_window_gen #(
  parameter int CHANNELS     = 3,
  parameter int PIXEL_WIDTH  = 8,
  parameter int KERNEL       = 3,
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  localparam int WINDOW_ELEMS = KERNEL * KERNEL
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [CHANNELS-1:0][PIXEL_WIDTH-1:0]                  in_px,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  output logic [CHANNELS-1:0][WINDOW_ELEMS-1:0][PIXEL_WIDTH-1:0] window_per_channel,
  output logic                                                  start,
  input  logic                                                  pe_done,
  output logic                                                  frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL - 1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            last_q, last_d;
  logic            start_q, start_d;
  logic            frame_done_q, frame_done_d;
  logic            accept_s;
  logic            win_complete_s;
  logic            at_last_s;

  logic [PIXEL_WIDTH-1:0] lb_q      [CHANNELS][KERNEL-1][IMG_W];
  logic [PIXEL_WIDTH-1:0] win_q     [CHANNELS][KERNEL][KERNEL];
  logic [PIXEL_WIDTH-1:0] new_col_s [CHANNELS][KERNEL];

  // in_ready is a pure state decode, forced low while reset is held
  assign in_ready       = (state_q == ST_ACCEPT) && !rst;
  assign accept_s       = in_valid && in_ready;
  assign win_complete_s = (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
  assign at_last_s      = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign start          = start_q;
  assign frame_done     = frame_done_q;

  // Raster counters and handshake FSM next-state
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    last_d       = last_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    if (accept_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    case (state_q)
      ST_ACCEPT: begin
        if (accept_s && win_complete_s) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          last_d  = at_last_s;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (pe_done) begin
          state_d      = ST_ACCEPT;
          frame_done_d = last_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Incoming column: buffered rows oldest first, the live pixel at the bottom
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int r = 0; r < KERNEL - 1; r++) begin
        new_col_s[ch][r] = lb_q[ch][r][col_q];
      end
      new_col_s[ch][KERNEL-1] = in_px[ch];
    end
  end

  // Line buffers (RAM-like, no reset): shift up one row at the current column
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int r = 0; r < KERNEL - 2; r++) begin
          lb_q[ch][r][col_q] <= lb_q[ch][r+1][col_q];
        end
        lb_q[ch][KERNEL-2][col_q] <= in_px[ch];
      end
    end
  end

  // Window register: shift left one column and load the incoming column
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL; c++) begin
            win_q[ch][r][c] <= '0;
          end
        end
      end
    end else if (accept_s) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) begin
            win_q[ch][r][c] <= win_q[ch][r][c+1];
          end
          win_q[ch][r][KERNEL-1] <= new_col_s[ch][r];
        end
      end
    end
  end

  // Flatten to element index r*K+c
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          window_per_channel[ch][r*KERNEL+c] = win_q[ch][r][c];
        end
      end
    end
  end

endmodule
